dff_share_arbiter: RTL and testbench

DFF_SHARE_ARBITER -- requirements
Module: dff_share_arbiter

---
 rtl/dff_arb_pkg.sv | 23 ++
 rtl/dff_share_arbiter_rr_pick.sv | 37 +++
 rtl/dff_share_arbiter.sv | 123 ++++++++++++
 tb/tb_dff_share_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// ============================================================================
// dff_arb_pkg : state encoding, timeout length and pointer helper for the
//               shared-register arbiter.             Rev 1.0
// ============================================================================
`default_nettype none

package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_REL = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES = 16;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_share_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, search starts at i_ptr.
//                                                     Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_winner = '0;
    o_index  = '0;
    o_any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      c = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[c]) begin
        o_winner    = '0;
        o_winner[c] = 1'b1;
        o_index     = IDX_W'(c);
        o_any       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dff_share_arbiter.sv
// ============================================================================
// dff_share_arbiter : round-robin arbitrated shared register, falling-edge.
// Optional forced release when DFF_ARB_TIMEOUT_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module dff_share_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        Clk_In,
  input  logic                        Reset_In,
  input  logic [NUM_REQ-1:0]          Req_In,
  input  logic [NUM_REQ*DATA_W-1:0]   Data_In,
  output logic [NUM_REQ-1:0]          Gnt_Out,
  output logic [$clog2(NUM_REQ)-1:0]  Owner_Out,
  output logic [DATA_W-1:0]           Q_Out,
  output logic [DATA_W-1:0]           Qb_Out,
  output logic                        Valid_Out,
  output logic                        Timeout_Out
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  arb_state_t           r_state;
  logic [c_IDX_W-1:0]   r_ptr;
  logic [c_IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [DATA_W-1:0]    r_q;
  logic                 r_valid;

  logic [NUM_REQ-1:0]   w_winner;
  logic [c_IDX_W-1:0]   w_index;
  logic                 w_any;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES);
  logic [c_TO_W-1:0]    r_to_cnt;
  logic                 r_timeout;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_pick (
    .i_req    (Req_In),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_index  (w_index),
    .o_any    (w_any)
  );

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
`ifdef DFF_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef DFF_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_index;
            r_gnt   <= w_winner;
            r_state <= GRANT;
          end
        end
        // Capture happens regardless of the owner still requesting.
        GRANT: begin
          r_gnt   <= '0;
          r_q     <= Data_In[int'(r_owner)*DATA_W +: DATA_W];
          r_valid <= 1'b1;
          r_ptr   <= c_IDX_W'(wrap_inc(int'(r_owner), NUM_REQ));
          r_state <= WAIT_REL;
`ifdef DFF_ARB_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        WAIT_REL: begin
          if (!Req_In[r_owner]) begin
            r_state <= IDLE;
          end
`ifdef DFF_ARB_TIMEOUT_EN
          else if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_to_cnt  <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Gnt_Out   = r_gnt;
  assign Owner_Out = r_owner;
  assign Q_Out     = r_q;
  assign Qb_Out    = ~r_q;
  assign Valid_Out = r_valid;

`ifdef DFF_ARB_TIMEOUT_EN
  assign Timeout_Out = r_timeout;
`else
  assign Timeout_Out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_share_arbiter.sv
// ============================================================================
// tb_dff_share_arbiter : directed vector bench for dff_share_arbiter.
//                                                     Rev 1.0
// ============================================================================
`default_nettype none

module tb_dff_share_arbiter;

  logic        Clk_In;
  logic        Reset_In;
  logic [3:0]  Req_In;
  logic [31:0] Data_In;
  logic [3:0]  Gnt_Out;
  logic [1:0]  Owner_Out;
  logic [7:0]  Q_Out;
  logic [7:0]  Qb_Out;
  logic        Valid_Out;
  logic        Timeout_Out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] own;
    logic [7:0] q;
    logic       v;
  } vec_t;

  vec_t       tbl[14];
  logic [7:0] dat[4];

  dff_share_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .Clk_In      (Clk_In),
    .Reset_In    (Reset_In),
    .Req_In      (Req_In),
    .Data_In     (Data_In),
    .Gnt_Out     (Gnt_Out),
    .Owner_Out   (Owner_Out),
    .Q_Out       (Q_Out),
    .Qb_Out      (Qb_Out),
    .Valid_Out   (Valid_Out),
    .Timeout_Out (Timeout_Out)
  );

  initial Clk_In = 1'b1;
  always #5 Clk_In = ~Clk_In;

  task automatic tick();
    @(negedge Clk_In);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [7:0] eq);
    logic [7:0] eqb;
    eqb = ~eq;
    chk({nm, " q"}, Q_Out, eq);
    chk({nm, " qb"}, Qb_Out, eqb);
  endtask

  initial begin
    logic [3:0] eg;
    logic       eto;
    int         e;

    dat[0] = 8'h11; dat[1] = 8'hA5; dat[2] = 8'h33; dat[3] = 8'hC4;
    Data_In  = {dat[3], dat[2], dat[1], dat[0]};
    Req_In   = '0;
    Reset_In = 1'b0;
    #1;

    //            rst   req      gnt      own   q      v
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 4'b0010, 4'b0000, 2'd1, 8'hA5, 1'b1};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 8'hA5, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 8'h33, 1'b1};
    tbl[6]  = '{1'b0, 4'b1001, 4'b0000, 2'd2, 8'h33, 1'b1};
    tbl[7]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 8'h33, 1'b1};
    tbl[8]  = '{1'b0, 4'b1001, 4'b0000, 2'd3, 8'hC4, 1'b1};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0000, 2'd3, 8'hC4, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 8'hC4, 1'b1};
    tbl[11] = '{1'b0, 4'b0001, 4'b0000, 2'd0, 8'h11, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 8'h11, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 8'h11, 1'b1};

    for (int i = 0; i < 14; i++) begin
      Reset_In = tbl[i].rst;
      Req_In   = tbl[i].req;
      tick();
      chk($sformatf("row%0d gnt", i), Gnt_Out, tbl[i].gnt);
      chk($sformatf("row%0d owner", i), Owner_Out, tbl[i].own);
      chk_q($sformatf("row%0d", i), tbl[i].q);
      chk($sformatf("row%0d valid", i), Valid_Out, tbl[i].v);
      chk($sformatf("row%0d timeout", i), Timeout_Out, 1'b0);
    end

    // All four requesting; each owner releases once served.
    Reset_In = 1'b1;
    tick();
    Reset_In = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e  = i % 4;
      eg = 4'(1 << e);
      Req_In = 4'hF;
      tick();
      chk($sformatf("rot%0d gnt", i), Gnt_Out, eg);
      tick();
      chk_q($sformatf("rot%0d", i), dat[e]);
      chk($sformatf("rot%0d gnt_clear", i), Gnt_Out, 4'b0000);
      Req_In = 4'hF & ~eg;
      tick();
      chk($sformatf("rot%0d release", i), Gnt_Out, 4'b0000);
    end

    // Reset during GRANT: immediate clear, no capture.
    Req_In = 4'b0100;
    tick();
    chk("midrst pre gnt", Gnt_Out, 4'b0100);
    Reset_In = 1'b1;
    #1;
    chk("midrst gnt", Gnt_Out, 4'b0000);
    chk_q("midrst", 8'h00);
    chk("midrst valid", Valid_Out, 1'b0);
    chk("midrst owner", Owner_Out, 2'd0);
    #1;
    Reset_In = 1'b0;
    tick();
    chk("post rst gnt", Gnt_Out, 4'b0100);
    chk("post rst owner", Owner_Out, 2'd2);
    chk_q("post rst", 8'h00);
    chk("post rst valid", Valid_Out, 1'b0);
    tick();
    chk_q("post rst cap", 8'h33);
    chk("post rst cap valid", Valid_Out, 1'b1);

    // Owner holds its request in WAIT_REL for 20 cycles.
    for (int j = 1; j <= 20; j++) begin
      tick();
`ifdef DFF_ARB_TIMEOUT_EN
      eto = (j == 16);
      eg  = (j == 17) ? 4'b0100 : 4'b0000;
`else
      eto = 1'b0;
      eg  = 4'b0000;
`endif
      chk($sformatf("hold%0d timeout", j), Timeout_Out, eto);
      chk($sformatf("hold%0d gnt", j), Gnt_Out, eg);
    end
    Req_In = 4'b0000;
    tick();
    chk("drop gnt", Gnt_Out, 4'b0000);
    tick();
    chk("idle gnt", Gnt_Out, 4'b0000);
    chk("idle timeout", Timeout_Out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
